// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
// Response codes are 3 bits here and are zero-extended to the bus response width at the top.
package axi_lite_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_lite_reg_file.sv
// Register bank with byte-strobed write port, combinational read port and flat export.
module axi_lite_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_WIDTH  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IDX_WIDTH-1:0]           wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IDX_WIDTH-1:0]           rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = regs[rd_idx];

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_flat
    assign reg_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder terminating a master port with a bank of word-addressed registers.
// Independent write and read FSMs; all bus outputs are registered.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [RESP_WIDTH-1:0]          s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = ADDR_WIDTH - 2;
  localparam int unsigned RI_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);
  localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);

  // Write path state
  w_state_e                w_state;
  logic                    awready_q, wready_q, bvalid_q;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;
  logic [RESP_WIDTH-1:0]   bresp_q;

  // Read path state
  r_state_e                r_state;
  logic                    arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [RESP_WIDTH-1:0]   rresp_q;

  logic                    aw_hs, w_hs, ar_hs, commit, wr_en;
  logic [ADDR_WIDTH-1:0]   cur_awaddr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [STRB_WIDTH-1:0]   cur_wstrb;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid & wready_q;
  assign ar_hs = s_axi_arvalid & arready_q;

  // The later of AW/W commits on its own handshake edge, so take it straight from the bus.
  assign cur_awaddr = aw_hs ? s_axi_awaddr : aw_addr_q;
  assign cur_wdata  = w_hs ? s_axi_wdata : w_data_q;
  assign cur_wstrb  = w_hs ? s_axi_wstrb[STRB_WIDTH-1:0] : w_strb_q;

  assign wr_idx      = cur_awaddr[ADDR_WIDTH-1:2];
  assign rd_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
  assign wr_in_range = {1'b0, wr_idx} < NUM_REGS_L;
  assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_L;

  assign commit = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
  assign wr_en  = commit && wr_in_range;

  logic unused_bits;
  assign unused_bits = ^{cur_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[STRB_WIDTH]};

  axi_lite_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_WIDTH  (RI_W)
  ) u_reg_file (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx[RI_W-1:0]),
    .wr_data  (cur_wdata),
    .wr_strb  (cur_wstrb),
    .rd_idx   (rd_idx[RI_W-1:0]),
    .rd_data  (rd_data),
    .reg_flat (reg_flat)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= s_axi_awaddr;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb[STRB_WIDTH-1:0];
            w_done   <= 1'b1;
          end
          if (commit) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_in_range ? OKAY : SLVERR;
            w_state   <= W_RESP;
          end else begin
            awready_q <= !(aw_done || aw_hs);
            wready_q  <= !(w_done || w_hs);
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // rd_data is the pre-commit value, so a colliding read returns the old contents.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_in_range ? rd_data : '0;
            rresp_q   <= rd_in_range ? OKAY : SLVERR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: vector table of write/read pairs plus
// hand-sequenced latency, backpressure and mid-transaction reset cases.
module tb_axi_lite_reg_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned NR = 8;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   awaddr;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8:0]   wstrb;
  logic            wvalid, wready;
  logic [RW-1:0]   bresp;
  logic            bvalid, bready;
  logic [AW-1:0]   araddr;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic [RW-1:0]   rresp;
  logic            rvalid, rready;
  logic [NR*DW-1:0] reg_flat;

  int checks = 0;
  int failures = 0;

  axi_lite_reg_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW),
    .NUM_REGS   (NR)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_flat      (reg_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8:0] s, output logic [RW-1:0] resp);
    int n;
    logic aw_f, w_f;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_f) awvalid = 1'b0;
      if (w_f) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) check("write_handshake_timeout", 64'd0, 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) check("bvalid_timeout", 64'd0, 64'd1);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [RW-1:0] resp);
    int n;
    logic ar_f;
    araddr = a; rready = 1'b1; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      @(negedge clk);
      ar_f = arvalid && arready;
      @(posedge clk); #1;
      if (ar_f) arvalid = 1'b0;
      n++;
    end
    if (arvalid) check("read_handshake_timeout", 64'd0, 64'd1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) check("rvalid_timeout", 64'd0, 64'd1);
    d = rdata;
    resp = rresp;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [DW/8:0]  strb;
    logic [RW-1:0]  exp_bresp;
    logic [DW-1:0]  exp_rdata;
    logic [RW-1:0]  exp_rresp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [RW-1:0] r;
    logic [DW-1:0] d;

    vecs[0] = '{8'h08, 32'h0000_00C3, 5'h0F, 3'd0, 32'h0000_00C3, 3'd0};
    vecs[1] = '{8'h04, 32'hFFFF_FFFF, 5'h0F, 3'd0, 32'hFFFF_FFFF, 3'd0};
    vecs[2] = '{8'h04, 32'h1234_5678, 5'h05, 3'd0, 32'hFF34_FF78, 3'd0};
    vecs[3] = '{8'h20, 32'h0000_DEAD, 5'h0F, 3'd2, 32'h0000_0000, 3'd2};
    vecs[4] = '{8'h1C, 32'hA5A5_A5A5, 5'h13, 3'd0, 32'h0000_A5A5, 3'd0};
    vecs[5] = '{8'h1E, 32'h1122_3344, 5'h08, 3'd0, 32'h1100_A5A5, 3'd0};
    vecs[6] = '{8'hFC, 32'h5555_5555, 5'h0F, 3'd2, 32'h0000_0000, 3'd2};

    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_flat_zero", 64'(reg_flat === '0), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("awready_before_first_edge", 64'(awready), 64'd0);
    @(negedge clk);
    check("awready_after_reset", 64'(awready), 64'd1);
    check("wready_after_reset", 64'(wready), 64'd1);
    check("arready_after_reset", 64'(arready), 64'd1);

    // Same-cycle AW+W, bvalid next cycle
    awaddr = 8'h00; wdata = 32'd56; wstrb = 5'h0F; bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("seq1_bvalid", 64'(bvalid), 64'd1);
    check("seq1_bresp", 64'(bresp), 64'd0);
    check("seq1_awready_low", 64'(awready), 64'd0);
    @(negedge clk);
    check("seq1_bvalid_cleared", 64'(bvalid), 64'd0);
    check("seq1_awready_back", 64'(awready), 64'd1);
    check("seq1_flat", 64'(reg_flat[31:0]), 64'd56);
    // Read latency: rvalid one cycle after AR handshake
    araddr = 8'h00; rready = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("seq1_rvalid", 64'(rvalid), 64'd1);
    check("seq1_rdata", 64'(rdata), 64'd56);
    check("seq1_rresp", 64'(rresp), 64'd0);
    @(posedge clk); #1;

    // W arrives 3 cycles ahead of AW
    @(negedge clk);
    wdata = 32'd37; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("seq2_wready_low", 64'(wready), 64'd0);
    check("seq2_awready_high", 64'(awready), 64'd1);
    check("seq2_no_bvalid", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 8'd20; awvalid = 1'b1;
    @(negedge clk);
    check("seq2_bvalid_before_aw", 64'(bvalid), 64'd0);
    check("seq2_wready_still_low", 64'(wready), 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("seq2_bvalid", 64'(bvalid), 64'd1);
    check("seq2_bresp", 64'(bresp), 64'd0);
    @(posedge clk); #1;
    axi_read(8'd20, d, r);
    check("seq2_rdata", 64'(d), 64'd37);
    check("seq2_rresp", 64'(r), 64'd0);
    check("seq2_flat", 64'(reg_flat[191:160]), 64'd37);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
      check($sformatf("vec%0d_bresp", i), 64'(r), 64'(vecs[i].exp_bresp));
      axi_read(vecs[i].addr, d, r);
      check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_rresp", i), 64'(r), 64'(vecs[i].exp_rresp));
    end
    check("flat_reg0_kept", 64'(reg_flat[31:0]), 64'd56);
    check("flat_reg1", 64'(reg_flat[63:32]), 64'hFF34_FF78);

    // Backpressure: hold bready/rready low for 4 cycles
    @(negedge clk);
    awaddr = 8'h08; wdata = 32'h0000_CAFE; wstrb = 5'h0F; bready = 1'b0;
    araddr = 8'h04; rready = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_bvalid", c), 64'(bvalid), 64'd1);
      check($sformatf("bp%0d_bresp", c), 64'(bresp), 64'd0);
      check($sformatf("bp%0d_rvalid", c), 64'(rvalid), 64'd1);
      check($sformatf("bp%0d_rdata", c), 64'(rdata), 64'hFF34_FF78);
      check($sformatf("bp%0d_readies", c), 64'({awready, wready, arready}), 64'd0);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    check("bp_release_valids", 64'({bvalid, rvalid}), 64'd0);
    check("bp_release_readies", 64'({awready, wready, arready}), 64'h7);
    check("bp_flat_reg2", 64'(reg_flat[95:64]), 64'h0000_CAFE);

    // Reset while both responses pending
    awaddr = 8'h0C; wdata = 32'h55; wstrb = 5'h0F; bready = 1'b0;
    araddr = 8'h04; rready = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("rst6_pre_valids", 64'({bvalid, rvalid}), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    check("rst6_valids", 64'({bvalid, rvalid}), 64'd0);
    check("rst6_readies", 64'({awready, wready, arready}), 64'd0);
    check("rst6_rdata", 64'(rdata), 64'd0);
    check("rst6_bresp_rresp", 64'({bresp, rresp}), 64'd0);
    check("rst6_flat_zero", 64'(reg_flat === '0), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    axi_read(8'h04, d, r);
    check("rst6_read_cleared", 64'(d), 64'd0);
    axi_write(8'h08, 32'd7, 5'h0F, r);
    check("rst6_write_bresp", 64'(r), 64'd0);
    axi_read(8'h08, d, r);
    check("rst6_read_back", 64'(d), 64'd7);
    check("rst6_flat_reg2", 64'(reg_flat[95:64]), 64'd7);
    check("rst6_flat_reg3", 64'(reg_flat[127:96]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder that terminates one bus master port (m1 or m2) with a bank of word-addressed read/write registers. It accepts write address and write data independently, commits strobed writes, and returns write and read responses with backpressure. Register contents are also exported as a flat vector so downstream logic can observe configuration.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8.
ADDR_WIDTH, 8, byte address width.
RESP_WIDTH, 3, response field width; codes zero-extended.
NUM_REGS, 8, number of DATA_WIDTH registers; index = addr[ADDR_WIDTH-1:2].

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; MSB ignored
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_flat  out  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Single clock s_axi_aclk. Reset is asynchronous and active-low on s_axi_aresetn. All outputs are registered.
- Reset values: all registers 0, and all outputs 0 (including ready signals). awready, wready and arready rise at the first clock edge after reset deasserts.
- Response codes: OKAY=0, SLVERR=2. An address with index >= NUM_REGS gets SLVERR. addr[1:0] is ignored.
- Write path, FSM W_IDLE -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1 until an AW handshake, then the address is latched and awready drops. wready=1 until a W handshake, then data and strobe are latched and wready drops.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
  - On the edge after both are latched: commit the write (only bytes with strobe=1; no commit if out of range), set bvalid=1 with bresp, and enter W_RESP.
  - Latency from the later of the two handshakes to bvalid is 1 cycle.
  - W_RESP: hold bvalid and bresp stable until bready=1. On that edge clear bvalid and raise awready and wready together.
  - No new AW or W is accepted while a write is latched or a response is pending.
- Read path, FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On an AR handshake, register the addressed contents into rdata (0 if out of range), set rresp, raise rvalid on the same edge, and drop arready.
  - Latency: rvalid is asserted the cycle after the AR handshake.
  - R_DATA: hold rdata and rresp stable until rready=1. On that edge clear rvalid and raise arready.
- The read and write paths are fully independent and may be active concurrently.
- Read/write collision: if a write commits on the same edge as an AR handshake to the same index, the read returns the pre-write value.
- reg_flat reflects a commit on the cycle after the commit edge (it is driven directly from the registers).
- Reset mid-transaction: latched AW/W data and pending B/R responses are discarded, and the next transaction starts clean.
- Valid signals are not required to stay low between transactions; a held awvalid is accepted again once awready returns.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=0, RESP_SLVERR=2 (RESP_WIDTH wide); write FSM state constants W_IDLE/W_RESP; read FSM state constants R_IDLE/R_DATA.
- One sub-module, axi_lite_reg_file:
  - NUM_REGS x DATA_WIDTH storage.
  - Write port: index, data, strobe, enable.
  - Combinational read port.
  - Flat output.
  - Asynchronous active-low reset to 0.
- The top module holds both FSMs and the address decode.

Test Plan:
1. After reset: AW addr=0, W data=56, strb=15 in the same cycle, bready=1 -> bvalid the next cycle, bresp=0. Then read addr=0 -> rvalid 1 cycle after AR, rdata=56, rresp=0, and reg_flat[31:0]=56.
2. W data=37, strb=15 presented 3 cycles before AW addr=20 -> wready drops after the W handshake, bvalid 1 cycle after the AW handshake. Reading addr=20 returns 37, and reg_flat[191:160]=37.
3. Write 0xFFFFFFFF to addr 4, then write 0x12345678 with strb=4'b0101 -> reading addr 4 returns 0xFF34FF78.
4. Write addr=32 (index 8) with data 0xDEAD -> bresp=2, no register changes. Read addr=32 -> rresp=2, rdata=0.
5. Hold bready=0 for 4 cycles after bvalid, and rready=0 for 4 cycles after rvalid -> bvalid/bresp and rvalid/rdata stay stable; awready, wready and arready stay 0 until the respective ready handshake.
6. Assert reset for 1 cycle while bvalid=1 and rvalid=1 -> all outputs go to 0 immediately, registers read back 0, and a fresh write to addr 8 with data 7 then completes normally.
